// File: rtl/edge_pulse_pkg.sv
// Shared types and width helpers for the edge/level pulse generator.
package edge_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_RISE   = 2'b00,
    MODE_FALL   = 2'b01,
    MODE_BOTH   = 2'b10,
    MODE_REPEAT = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/edge_pulse_channel.sv
// One channel: synchroniser, debounce, repeat FSM and registered pulse.
//   state       | meaning
//   IDLE        | no hold in progress
//   HOLD_DELAY  | press seen, waiting out the initial repeat delay
//   HOLD_REPEAT | held past the delay, pulsing every repeat period
module edge_pulse_channel
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  level_i,
  input  mode_t mode_i,
  output logic  pulse_d_o,
  output logic  pulse_o,
  output logic  level_o
);

  localparam int DB_W  = cnt_width(DEBOUNCE_CYCLES + 1);
  localparam int REP_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_out;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   db_level_q, db_level_d;
  logic                   rise_ev, fall_ev;
  mode_t                  mode_q;
  rep_state_t             state_q, state_d;
  logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
  logic                   pulse_q, pulse_d;

  assign s_out = sync_q[SYNC_STAGES-1];

  // Counter only advances on a mismatch and clears on acceptance, so it never wraps.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (s_out != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES)) db_level_d = s_out;
      else                                    db_cnt_d   = db_cnt_q + 1'b1;
    end
  end

  assign rise_ev = db_level_d & ~db_level_q;
  assign fall_ev = ~db_level_d & db_level_q;

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    pulse_d   = 1'b0;
    if (mode_i != mode_q) begin
      state_d   = IDLE;
      rep_cnt_d = '0;
    end else begin
      case (mode_i)
        MODE_RISE: begin
          pulse_d = rise_ev; state_d = IDLE; rep_cnt_d = '0;
        end
        MODE_FALL: begin
          pulse_d = fall_ev; state_d = IDLE; rep_cnt_d = '0;
        end
        MODE_BOTH: begin
          pulse_d = rise_ev | fall_ev; state_d = IDLE; rep_cnt_d = '0;
        end
        MODE_REPEAT: begin
          case (state_q)
            IDLE: begin
              if (rise_ev) begin
                pulse_d   = 1'b1;
                state_d   = HOLD_DELAY;
                rep_cnt_d = REP_W'(REPEAT_DELAY - 1);
              end
            end
            HOLD_DELAY, HOLD_REPEAT: begin
              // Release takes priority over a coincident expiry.
              if (!db_level_d) begin
                state_d   = IDLE;
                rep_cnt_d = '0;
              end else if (rep_cnt_q == '0) begin
                pulse_d   = 1'b1;
                state_d   = HOLD_REPEAT;
                rep_cnt_d = REP_W'(REPEAT_PERIOD - 1);
              end else begin
                rep_cnt_d = rep_cnt_q - 1'b1;
              end
            end
            default: begin
              state_d   = IDLE;
              rep_cnt_d = '0;
            end
          endcase
        end
        default: begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  // Tracked through reset so a mode held across reset release is not a change.
  always_ff @(posedge clk) mode_q <= mode_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      state_q    <= IDLE;
      rep_cnt_q  <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], level_i};
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse_d_o = reset ? 1'b0 : pulse_d;
  assign pulse_o   = pulse_q;
  assign level_o   = db_level_q;

endmodule

// File: rtl/edge_pulse_gen.sv
// Multi-channel level-to-pulse converter with a registered any-pulse flag.
module edge_pulse_gen
  import edge_pulse_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   level_in,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   pulse_out,
  output logic [N_CH-1:0]   level_out,
  output logic              any_pulse
);

  logic [N_CH-1:0] pulse_nxt;
  logic            any_pulse_q;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    edge_pulse_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .level_i  (level_in[gi]),
      .mode_i   (mode_t'(mode[2*gi +: 2])),
      .pulse_d_o(pulse_nxt[gi]),
      .pulse_o  (pulse_out[gi]),
      .level_o  (level_out[gi])
    );
  end

  // Built from the channels' next-pulse terms so it lands with pulse_out.
  always_ff @(posedge clk) begin
    if (reset) any_pulse_q <= 1'b0;
    else       any_pulse_q <= |pulse_nxt;
  end

  assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_edge_pulse_gen.sv
// Scoreboard bench: two DUTs (no debounce / 3-cycle debounce) against an event-level model.
module tb_edge_pulse_gen;

  localparam int NC = 4;
  localparam int S  = 2;
  localparam int RD = 8;
  localparam int RP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NC-1:0] level_in;
  logic [2*NC-1:0] mode;
  logic [NC-1:0] po0, lo0, po1, lo1;
  logic          ap0, ap1;

  always #5 clk = ~clk;

  edge_pulse_gen #(.N_CH(NC)) dut0 (
    .clk(clk), .reset(reset), .level_in(level_in), .mode(mode),
    .pulse_out(po0), .level_out(lo0), .any_pulse(ap0)
  );

  edge_pulse_gen #(.N_CH(NC), .DEBOUNCE_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .level_in(level_in), .mode(mode),
    .pulse_out(po1), .level_out(lo1), .any_pulse(ap1)
  );

  typedef struct packed {
    logic [NC-1:0] p0, l0, p1, l1;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Model state
  bit       samp_q[NC][$];
  bit       db_m[2][NC];
  int       run_m[2][NC];
  bit       press_v[2][NC];
  int       press_t[2][NC];
  logic [1:0] prev_mode[NC];
  int       k = 0;

  task automatic ref_step();
    exp_t e;
    logic [1:0] m;
    bit chg, seen, old, rise, fall, p;
    int n, dbc, el;
    e = '0;
    k++;
    for (int c = 0; c < NC; c++) begin
      m = mode[2*c +: 2];
      chg = (m != prev_mode[c]);
      prev_mode[c] = m;
      if (reset) begin
        samp_q[c].delete();
        for (int u = 0; u < 2; u++) begin
          db_m[u][c] = 0; run_m[u][c] = 0; press_v[u][c] = 0;
        end
        continue;
      end
      n = samp_q[c].size();
      seen = (n >= S) ? samp_q[c][0] : 1'b0;
      samp_q[c].push_back(level_in[c]);
      if (samp_q[c].size() > S) void'(samp_q[c].pop_front());
      for (int u = 0; u < 2; u++) begin
        dbc = (u == 0) ? 0 : 3;
        old = db_m[u][c];
        if (seen != old) begin
          run_m[u][c]++;
          if (run_m[u][c] == dbc + 1) begin
            db_m[u][c] = seen; run_m[u][c] = 0;
          end
        end else run_m[u][c] = 0;
        rise = !old && db_m[u][c];
        fall = old && !db_m[u][c];
        p = 0;
        if (chg) press_v[u][c] = 0;
        else if (m == 2'b00) p = rise;
        else if (m == 2'b01) p = fall;
        else if (m == 2'b10) p = rise | fall;
        else begin
          if (rise) begin
            p = 1; press_v[u][c] = 1; press_t[u][c] = k;
          end else if (press_v[u][c]) begin
            if (!db_m[u][c]) press_v[u][c] = 0;
            else begin
              el = k - press_t[u][c];
              p = (el == RD) || (el > RD && ((el - RD) % RP) == 0);
            end
          end
        end
        if (m != 2'b11) press_v[u][c] = 0;
        if (u == 0) begin e.p0[c] = p; e.l0[c] = db_m[u][c]; end
        else        begin e.p1[c] = p; e.l1[c] = db_m[u][c]; end
      end
    end
    sbq.push_back(e);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) prev_mode[c] = 2'b00;
    forever begin
      @(posedge clk);
      ref_step();
    end
  end

  task automatic chk(input string nm, input logic [NC-1:0] act, input logic [NC-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pulse0", po0, e.p0);
        chk("level0", lo0, e.l0);
        chk1("any0", ap0, |e.p0);
        chk("pulse1", po1, e.p1);
        chk("level1", lo1, e.l1);
        chk1("any1", ap1, |e.p1);
      end
    end
  end

  task automatic run(input logic [NC-1:0] lv, input logic [2*NC-1:0] md, input int n);
    level_in = lv;
    mode     = md;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    logic [NC-1:0]   lv;
    logic [2*NC-1:0] md;
    int dur;
    reset    = 1'b1;
    level_in = '0;
    mode     = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run(4'h0, 8'h00, 5);
    // rise on ch0
    run(4'h1, 8'h00, 12);
    run(4'h0, 8'h00, 12);
    // short glitch: rejected only by the debounced instance
    run(4'h1, 8'h00, 2);
    run(4'h0, 8'h00, 10);
    // both mode on ch1
    run(4'h0, 8'b00_00_10_00, 3);
    run(4'h2, 8'b00_00_10_00, 10);
    run(4'h0, 8'b00_00_10_00, 10);
    // auto-repeat on ch2, long hold then release
    run(4'h0, 8'b00_11_00_00, 3);
    run(4'h4, 8'b00_11_00_00, 30);
    run(4'h0, 8'b00_11_00_00, 10);
    // switch to rise mid-repeat, then a fresh press
    run(4'h4, 8'b00_11_00_00, 20);
    run(4'h4, 8'b00_00_00_00, 15);
    run(4'h0, 8'b00_00_00_00, 6);
    run(4'h4, 8'b00_00_00_00, 10);
    run(4'h0, 8'b00_00_00_00, 6);
    // reset mid HOLD_DELAY on ch3 with input held
    run(4'h0, 8'b11_00_00_00, 3);
    run(4'h8, 8'b11_00_00_00, 9);
    level_in = 4'h8;
    do_reset(2);
    run(4'h8, 8'b11_00_00_00, 30);
    run(4'h0, 8'b11_00_00_00, 8);
    // randomized segments
    lv = '0;
    md = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      lv = lv ^ 4'($urandom_range(0, 15));
      if ($urandom_range(0, 6) == 0) md = 8'($urandom);
      dur = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 10);
      if ($urandom_range(0, 50) == 0) begin
        level_in = lv;
        do_reset($urandom_range(1, 3));
      end
      run(lv, md, dur);
    end
    run(4'h0, md, 10);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/edge_pulse_gen.md
Name: edge_pulse_gen

Overview:
- Multi-channel, parametrised level-to-pulse converter for pushbuttons, switches and asynchronous strobes.
- Per channel, the block:
  - synchronises the raw level to clk;
  - debounces it;
  - emits single-cycle pulses on rising, falling or both edges, or auto-repeat pulses while held.
- Sits between board I/O and the control FSMs and counters of the lab designs.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
- DEBOUNCE_CYCLES, 0, extra consecutive cycles a new level must persist before acceptance (0 = no debounce)
- REPEAT_DELAY, 8, cycles from the initial press pulse to the first repeat pulse (>=1)
- REPEAT_PERIOD, 4, cycles between subsequent repeat pulses (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- level_in  in  N_CH  raw asynchronous levels, bit i = channel i
- mode  in  2*N_CH  per-channel mode, bits [2i+1:2i]: 00 rise, 01 fall, 10 both, 11 auto-repeat
- pulse_out  out  N_CH  one-cycle pulses, bit i = channel i
- level_out  out  N_CH  debounced, synchronised level
- any_pulse  out  1  registered OR of the pulse_out bits computed at the same edge (same cycle as pulse_out)

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - clears all synchroniser FFs, db_level, counters and the FSM (to IDLE);
  - forces pulse_out, level_out and any_pulse to 0.
  - Reset mid-operation aborts any pending debounce or repeat, with no pulse.
- Synchroniser: shift chain of SYNC_STAGES FFs; s_out is the last stage.
- Debounce:
  - db_level toggles at the clock edge where s_out != db_level has held for DEBOUNCE_CYCLES+1 consecutive edges.
  - Any edge with s_out == db_level clears the counter.
  - With DEBOUNCE_CYCLES = 0, db_level follows s_out one edge later.
  - level_out = db_level.
- Latency: level_in stable from before edge 0 -> db_level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES. The pulse is high for exactly the following cycle.
  - Defaults: high between edges 2 and 3.
- Pulse register: set at the same edge db_level changes. Pulses are registered outputs, exactly one cycle wide.
- Per-channel FSM (states IDLE, HOLD_DELAY, HOLD_REPEAT):
  - rise mode: pulse on 0->1 of db_level; FSM stays IDLE.
  - fall mode: pulse on 1->0; FSM stays IDLE.
  - both mode: pulse on either transition; FSM stays IDLE.
  - auto-repeat, IDLE -> HOLD_DELAY: on 0->1, pulse and load rep_cnt = REPEAT_DELAY-1.
  - HOLD_DELAY, count: decrement each cycle while db_level = 1.
  - HOLD_DELAY -> HOLD_REPEAT: at rep_cnt = 0, pulse and load REPEAT_PERIOD-1.
  - HOLD_REPEAT, count: at rep_cnt = 0, pulse and reload REPEAT_PERIOD-1.
  - Any state -> IDLE: db_level = 0 returns to IDLE with no pulse; a release on the same cycle as a repeat expiry wins (no pulse).
  - Spacing: first repeat pulse is REPEAT_DELAY cycles after the press pulse; later ones are REPEAT_PERIOD apart.
- Mode change: mode is sampled every cycle.
  - When the mode field differs from the previous cycle's value, the FSM returns to IDLE and rep_cnt clears.
  - No pulse is emitted for an edge on that same cycle.
  - The synchroniser and debounce logic are unaffected.
- Power-on high input: because the synchroniser resets to 0, a level_in held at 1 through reset release produces a rising event after the normal latency.
- Widths:
  - debounce counter = $clog2(DEBOUNCE_CYCLES+1), minimum 1 bit;
  - rep_cnt = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), minimum 1 bit;
  - counters saturate and never wrap.
- Channels are fully independent; simultaneous events on different channels each produce their own pulse.

Decomposition:
- Package edge_pulse_pkg:
  - enum mode_t {MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_REPEAT=2'b11};
  - enum rep_state_t {IDLE, HOLD_DELAY, HOLD_REPEAT};
  - helper constant function for counter widths.
- Sub-module edge_pulse_channel: one channel containing the synchroniser, debounce, FSM and pulse register.
- The top generates N_CH instances and the any_pulse OR.

Test Plan:
- Default parameters, ch0 rise mode: level_in[0] 0->1 before edge 0 -> pulse_out[0] = 1 only between edges 2 and 3; level_out[0] = 1 from edge 2; any_pulse matches.
- DEBOUNCE_CYCLES=3, rise mode: 0->1 glitch lasting 2 cycles -> no pulse, level_out stays 0; a 6-cycle high -> one pulse at edge 2+3.
- Both mode: high for 10 cycles then low -> two one-cycle pulses, 10 cycles apart.
- Auto-repeat (REPEAT_DELAY=8, REPEAT_PERIOD=4), held 25 cycles after press pulse at cycle t -> pulses at t, t+8, t+12, t+16, t+20, t+24; release -> no further pulses and FSM returns to IDLE.
- Mode switch from repeat to rise during HOLD_REPEAT -> no repeat pulses afterwards; the next 0->1 gives a single pulse.
- Reset asserted mid HOLD_DELAY with input held high -> all outputs 0 the next cycle; after release, one new press pulse after 2 cycles, then repeats restart from REPEAT_DELAY.
